// File: rtl/video_pkg.sv
// Shared encodings, bar colour table and format helpers for video_pattern_gen.
package video_pkg;

    localparam logic [1:0] PAT_BAR   = 2'd0;
    localparam logic [1:0] PAT_GRAY  = 2'd1;
    localparam logic [1:0] PAT_CHK   = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    // One full-scale flag per channel {R,G,B}; entry 0 is the leftmost bar.
    localparam logic [2:0] BAR_COLOURS [8] = '{
        3'b111,  // white
        3'b110,  // yellow
        3'b011,  // cyan
        3'b010,  // green
        3'b101,  // magenta
        3'b100,  // red
        3'b001,  // blue
        3'b000   // black
    };

    function automatic int unsigned h_total(input int unsigned sync, input int unsigned bp,
                                            input int unsigned active, input int unsigned fp);
        return sync + bp + active + fp;
    endfunction

    function automatic int unsigned v_total(input int unsigned sync, input int unsigned bp,
                                            input int unsigned active, input int unsigned fp);
        return sync + bp + active + fp;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Horizontal/vertical raster counters with region decode and frame-boundary strobes.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        hs_o,
    output logic        vs_o,
    output logic        h_active_o,
    output logic        v_active_o,
    output logic        line_start_o,
    output logic        frame_bnd_o,
    output logic [10:0] h_pos_o,
    output logic [10:0] v_pos_o
);

    localparam int unsigned H_TOTAL = h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int unsigned V_TOTAL = v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam int unsigned HA_START = H_SYNC + H_BP;
    localparam int unsigned HA_END   = H_SYNC + H_BP + H_ACTIVE;
    localparam int unsigned VA_START = V_SYNC + V_BP;
    localparam int unsigned VA_END   = V_SYNC + V_BP + V_ACTIVE;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [31:0]   h_w, v_w;
    logic          h_wrap, v_wrap;

    assign h_w    = 32'(h_cnt_q);
    assign v_w    = 32'(v_cnt_q);
    assign h_wrap = (h_cnt_q == H_LAST);
    assign v_wrap = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        hs_o         = (h_w < H_SYNC);
        vs_o         = (v_w < V_SYNC);
        h_active_o   = (h_w >= HA_START) && (h_w < HA_END);
        v_active_o   = (v_w >= VA_START) && (v_w < VA_END);
        line_start_o = (h_w == HA_START);
        frame_bnd_o  = (h_cnt_q == '0) && (v_cnt_q == '0);
        // Only meaningful inside the active window; the consumer gates them with DE.
        h_pos_o      = 11'(h_w - HA_START);
        v_pos_o      = 11'(v_w - VA_START);
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator (bar / gray ramp / checker / solid).
// Define VIDEO_PATTERN_SCROLL_EN to make the colour bars scroll left one pixel per frame.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_BARS = 8,
    parameter int unsigned CHK_LOG2 = 4
) (
    input  logic                pixel_clk,
    input  logic                sys_rst_n,
    input  logic [1:0]          pattern_sel,
    input  logic [3*DATA_W-1:0] solid_rgb,
    output logic                video_de,
    output logic                video_hs,
    output logic                video_vs,
    output logic [3*DATA_W-1:0] video_rgb,
    output logic [10:0]         pixel_xpos,
    output logic [10:0]         pixel_ypos,
    output logic                frame_start
);

    localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;
    localparam int unsigned SW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int unsigned IW    = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

    localparam logic [SW-1:0] SUB_LAST = SW'(BAR_W - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_BARS - 1);

    if ((H_ACTIVE % NUM_BARS) != 0) begin : g_bad_bars
        $error("H_ACTIVE must be a multiple of NUM_BARS");
    end
    if ((DATA_W > 11) || (CHK_LOG2 > 10)) begin : g_bad_widths
        $error("DATA_W must be <= 11 and CHK_LOG2 <= 10");
    end

    logic        hs_dec, vs_dec, h_act, v_act, line_start, frame_bnd;
    logic [10:0] h_pos, v_pos;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i        (pixel_clk),
        .rst_ni       (sys_rst_n),
        .hs_o         (hs_dec),
        .vs_o         (vs_dec),
        .h_active_o   (h_act),
        .v_active_o   (v_act),
        .line_start_o (line_start),
        .frame_bnd_o  (frame_bnd),
        .h_pos_o      (h_pos),
        .v_pos_o      (v_pos)
    );

    // Frame-stable copies of the runtime controls.
    logic [1:0]          pat_q, pat_d;
    logic [3*DATA_W-1:0] solid_q, solid_d;

    always_comb begin
        pat_d   = pat_q;
        solid_d = solid_q;
        if (frame_bnd) begin
            pat_d   = pattern_sel;
            solid_d = solid_rgb;
        end
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pat_q   <= PAT_BAR;
            solid_q <= '0;
        end else begin
            pat_q   <= pat_d;
            solid_q <= solid_d;
        end
    end

    logic [SW-1:0] off_sub;
    logic [IW-1:0] off_bar;

`ifdef VIDEO_PATTERN_SCROLL_EN
    logic [SW-1:0] off_sub_q, off_sub_d;
    logic [IW-1:0] off_bar_q, off_bar_d;
    logic          armed_q, armed_d;

    // The first boundary after reset opens frame 0, which is drawn with a zero offset.
    always_comb begin
        off_sub_d = off_sub_q;
        off_bar_d = off_bar_q;
        armed_d   = armed_q;
        if (frame_bnd) begin
            armed_d = 1'b1;
            if (armed_q) begin
                if (off_sub_q == SUB_LAST) begin
                    off_sub_d = '0;
                    off_bar_d = (off_bar_q == IDX_LAST) ? '0 : off_bar_q + IW'(1);
                end else begin
                    off_sub_d = off_sub_q + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            off_sub_q <= '0;
            off_bar_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            off_sub_q <= off_sub_d;
            off_bar_q <= off_bar_d;
            armed_q   <= armed_d;
        end
    end

    assign off_sub = off_sub_q;
    assign off_bar = off_bar_q;
`else
    assign off_sub = '0;
    assign off_bar = '0;
`endif

    // Bar tracking: the registers hold the state for the current pixel except at line start.
    logic [SW-1:0] bar_sub_q, bar_sub_d, cur_sub;
    logic [IW-1:0] bar_idx_q, bar_idx_d, cur_idx;

    always_comb begin
        cur_sub   = line_start ? off_sub : bar_sub_q;
        cur_idx   = line_start ? off_bar : bar_idx_q;
        bar_sub_d = bar_sub_q;
        bar_idx_d = bar_idx_q;
        if (h_act) begin
            if (cur_sub == SUB_LAST) begin
                bar_sub_d = '0;
                bar_idx_d = (cur_idx == IDX_LAST) ? '0 : cur_idx + IW'(1);
            end else begin
                bar_sub_d = cur_sub + SW'(1);
                bar_idx_d = cur_idx;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bar_sub_q <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_sub_q <= bar_sub_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    logic [2:0]          bar_flags;
    logic [3*DATA_W-1:0] pix;

    always_comb begin
        bar_flags = BAR_COLOURS[3'(cur_idx)];
        pix       = '0;
        unique case (pat_q)
            PAT_BAR:   pix = {{DATA_W{bar_flags[2]}}, {DATA_W{bar_flags[1]}},
                              {DATA_W{bar_flags[0]}}};
            PAT_GRAY:  pix = {3{h_pos[DATA_W-1:0]}};
            PAT_CHK:   pix = {(3*DATA_W){h_pos[CHK_LOG2] ^ v_pos[CHK_LOG2]}};
            PAT_SOLID: pix = solid_q;
        endcase
    end

    // Output stage: everything is registered together so the DVI side sees aligned signals.
    logic                de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [3*DATA_W-1:0] rgb_q, rgb_d;
    logic [10:0]         xpos_q, xpos_d, ypos_q, ypos_d;

    always_comb begin
        de_d   = h_act && v_act;
        hs_d   = hs_dec ? HS_POL : ~HS_POL;
        vs_d   = vs_dec ? VS_POL : ~VS_POL;
        rgb_d  = de_d ? pix : '0;
        xpos_d = de_d ? h_pos : '0;
        ypos_d = de_d ? v_pos : '0;
        fs_d   = de_d && (h_pos == '0) && (v_pos == '0);
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            de_q   <= 1'b0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            rgb_q  <= '0;
            xpos_q <= '0;
            ypos_q <= '0;
            fs_q   <= 1'b0;
        end else begin
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            rgb_q  <= rgb_d;
            xpos_q <= xpos_d;
            ypos_q <= ypos_d;
            fs_q   <= fs_d;
        end
    end

    assign video_de    = de_q;
    assign video_hs    = hs_q;
    assign video_vs    = vs_q;
    assign video_rgb   = rgb_q;
    assign pixel_xpos  = xpos_q;
    assign pixel_ypos  = ypos_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Randomised bench for video_pattern_gen on a small format, checked against a raster model.
module tb_video_pattern_gen;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 1;
    localparam int NUM_BARS = 4;
    localparam int CHK_LOG2 = 2;
    localparam int DATA_W   = 8;
    localparam int H_TOT    = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT    = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int F_TOT    = H_TOT * V_TOT;
    localparam int BAR_W    = H_ACTIVE / NUM_BARS;
`ifdef VIDEO_PATTERN_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic        pixel_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic        video_de, video_hs, video_vs, frame_start;
    logic [23:0] video_rgb;
    logic [10:0] pixel_xpos, pixel_ypos;

    video_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (1'b1),
        .VS_POL   (1'b1),
        .DATA_W   (DATA_W),
        .NUM_BARS (NUM_BARS),
        .CHK_LOG2 (CHK_LOG2)
    ) dut (
        .pixel_clk   (pixel_clk),
        .sys_rst_n   (sys_rst_n),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .video_de    (video_de),
        .video_hs    (video_hs),
        .video_vs    (video_vs),
        .video_rgb   (video_rgb),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .frame_start (frame_start)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int tcount = 0;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int          sched [8] = '{0, 3, 2, 1, 0, 3, 2, 0};
    int          pat_hist [32];
    logic [23:0] solid_hist [32];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_de"}, 32'(video_de), 0);
        check_eq({tag, "_hs"}, 32'(video_hs), 0);
        check_eq({tag, "_vs"}, 32'(video_vs), 0);
        check_eq({tag, "_rgb"}, 32'(video_rgb), 0);
        check_eq({tag, "_x"}, 32'(pixel_xpos), 0);
        check_eq({tag, "_y"}, 32'(pixel_ypos), 0);
        check_eq({tag, "_fs"}, 32'(frame_start), 0);
    endtask

    // Expected outputs for the raster position reached t cycles after reset release.
    task automatic check_pixel(input int t);
        int h, v, f, x, y, off, idx;
        bit de;
        logic [23:0] rgb;
        h   = t % H_TOT;
        v   = (t / H_TOT) % V_TOT;
        f   = t / F_TOT;
        de  = (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACTIVE) &&
              (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACTIVE);
        x   = de ? h - (H_SYNC + H_BP) : 0;
        y   = de ? v - (V_SYNC + V_BP) : 0;
        rgb = 24'h0;
        if (de) begin
            case (pat_hist[f])
                0: begin
                    off = SCROLL ? (f % H_ACTIVE) : 0;
                    idx = (((x + off) % H_ACTIVE) / BAR_W) % 8;
                    rgb = bar_tab[idx];
                end
                1: rgb = {3{8'(x)}};
                2: rgb = (((x / (1 << CHK_LOG2)) + (y / (1 << CHK_LOG2))) % 2) != 0 ?
                         24'hFFFFFF : 24'h000000;
                default: rgb = solid_hist[f];
            endcase
        end
        check_eq($sformatf("de@%0d", t), 32'(video_de), 32'(de));
        check_eq($sformatf("hs@%0d", t), 32'(video_hs), 32'(h < H_SYNC));
        check_eq($sformatf("vs@%0d", t), 32'(video_vs), 32'(v < V_SYNC));
        check_eq($sformatf("rgb@%0d", t), 32'(video_rgb), 32'(rgb));
        check_eq($sformatf("x@%0d", t), 32'(pixel_xpos), 32'(x));
        check_eq($sformatf("y@%0d", t), 32'(pixel_ypos), 32'(y));
        check_eq($sformatf("fs@%0d", t), 32'(frame_start), 32'(de && x == 0 && y == 0));
    endtask

    // Drive inputs for the next edge, record what the frame boundary samples, then check.
    task automatic run(input int n);
        int p, f;
        for (int k = 0; k < n; k++) begin
            p = tcount % F_TOT;
            f = tcount / F_TOT;
            if (p == 100) begin
                pattern_sel = 2'(sched[(f + 1) % 8]);
                solid_rgb   = (f == 0) ? 24'h123456 : 24'($urandom);
            end else if (p > 0 && p < 100 && ($urandom_range(0, 7) == 0)) begin
                pattern_sel = 2'($urandom);
                solid_rgb   = 24'($urandom);
            end
            if (p == 0) begin
                pat_hist[f]   = int'(pattern_sel);
                solid_hist[f] = solid_rgb;
            end
            @(posedge pixel_clk);
            #1;
            check_pixel(tcount);
            tcount++;
        end
    endtask

    initial begin
        repeat (3) @(posedge pixel_clk);
        #1;
        check_reset("por");
        @(negedge pixel_clk);
        sys_rst_n = 1'b1;
        tcount = 0;
        // Stop inside an active line so the reset lands mid-frame with DE high.
        run(7 * F_TOT + 3 * H_TOT + 10);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_reset("mid");
        @(posedge pixel_clk);
        #1;
        check_reset("held");
        @(negedge pixel_clk);
        sys_rst_n = 1'b1;
        tcount = 0;
        run(5 * F_TOT + 20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
